// File: rtl/conv_code_pkg.sv
// conv_code_pkg: constants and helpers for the rate-1/2, K=3 (5/7 octal)
// convolutional code.
//   expected_pair(s, a): returns {e1, e0}, the code pair the encoder emits
//   when it is in state s = {d[-1], d[-2]} and takes input a = d.
package conv_code_pkg;

    localparam int K        = 3;
    localparam int N_STATES = 4;

    // Generator taps, ordered {d, d[-1], d[-2]}
    localparam logic [K-1:0] G0 = 3'b101;
    localparam logic [K-1:0] G1 = 3'b111;

    typedef logic [1:0] state_t;

    function automatic logic [1:0] expected_pair(state_t s, logic a);
        logic [K-1:0] taps;
        taps = {a, s};
        return {^(taps & G1), ^(taps & G0)};
    endfunction

endpackage

// File: rtl/viterbi_decoder_if.sv
// viterbi_decoder_if: symbol-in / decoded-bit-out bus of the Viterbi decoder.
//   in_valid, c0, c1         : received code pair, accepted whenever in_valid is high
//   out_valid, out_bit       : single-cycle pulse carrying one decoded bit
//   best_metric [PM_W-1:0]   : pre-normalisation metric of the surviving path
//   master : symbol source / bit sink      slave : the decoder
interface viterbi_decoder_if #(parameter int PM_W = 6);

    logic            in_valid;
    logic            c0;
    logic            c1;
    logic            out_valid;
    logic            out_bit;
    logic [PM_W-1:0] best_metric;

    modport master (output in_valid, c0, c1,
                    input  out_valid, out_bit, best_metric);

    modport slave  (input  in_valid, c0, c1,
                    output out_valid, out_bit, best_metric);

endinterface

// File: rtl/viterbi_decoder_acs.sv
// viterbi_acs: add-compare-select for one trellis state.
//   pm0_i, pm1_i [PM_W-1:0] : metrics of predecessors {b,0} and {b,1}
//   bm0_i, bm1_i [1:0]      : branch metrics from those predecessors
//   sum_o [PM_W:0]          : surviving candidate, one bit wider so it cannot wrap
//   dec_o                   : 1 when predecessor {b,1} won; ties go to {b,0}
module viterbi_acs #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [1:0]      bm0_i,
    input  logic [1:0]      bm1_i,
    output logic [PM_W:0]   sum_o,
    output logic            dec_o
);

    logic [PM_W:0] cand0, cand1;

    assign cand0 = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0_i};
    assign cand1 = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1_i};
    assign dec_o = (cand1 < cand0);
    assign sum_o = dec_o ? cand1 : cand0;

endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision Viterbi decoder for the K=3, 5/7 octal code,
// register-exchange survivors, decoded bits released TB_DEPTH symbols late.
//   clk, reset (async, active-high), clear (sync restart, beats in_valid)
//   bus (slave) : in_valid/c0/c1 in, out_valid/out_bit/best_metric out
module viterbi_decoder
    import conv_code_pkg::*;
#(
    parameter int TB_DEPTH = 15,
    parameter int PM_W     = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    viterbi_decoder_if.slave   bus
);

    localparam int             CNT_W  = $clog2(TB_DEPTH + 1);
    // Non-zero start states begin far behind so the path from state 0 wins early
    localparam logic [PM_W-1:0] PM_OFF = PM_W'(1) << (PM_W - 1);
    localparam logic [N_STATES-1:0][PM_W-1:0] PM_INIT =
        {PM_OFF, PM_OFF, PM_OFF, {PM_W{1'b0}}};

    function automatic logic [1:0] hamming(logic r0, logic r1, logic [1:0] e);
        return {1'b0, r0 ^ e[0]} + {1'b0, r1 ^ e[1]};
    endfunction

    logic [N_STATES-1:0][PM_W-1:0]     pm_q, pm_d, pm_new;
    logic [N_STATES-1:0][TB_DEPTH-1:0] surv_q, surv_d, surv_new;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              out_valid_q, out_valid_d;
    logic                              out_bit_q, out_bit_d;
    logic [PM_W-1:0]                   best_metric_q, best_metric_d;

    logic [N_STATES-1:0][1:0]          bm0, bm1;
    logic [N_STATES-1:0][PM_W:0]       sum, norm;
    logic [N_STATES-1:0]               dec;
    logic [PM_W:0]                     min_w;
    state_t                            best;

    // Next state g = {a, b}; its predecessors are {b,0} and {b,1}
    for (genvar g = 0; g < N_STATES; g++) begin : g_acs
        localparam state_t P0 = state_t'((g % 2) * 2);
        localparam state_t P1 = state_t'((g % 2) * 2 + 1);
        localparam logic   A  = 1'(g / 2);

        assign bm0[g] = hamming(bus.c0, bus.c1, expected_pair(P0, A));
        assign bm1[g] = hamming(bus.c0, bus.c1, expected_pair(P1, A));

        viterbi_acs #(.PM_W(PM_W)) u_acs (
            .pm0_i (pm_q[P0]),
            .pm1_i (pm_q[P1]),
            .bm0_i (bm0[g]),
            .bm1_i (bm1[g]),
            .sum_o (sum[g]),
            .dec_o (dec[g])
        );

        assign surv_new[g] = {(dec[g] ? surv_q[P1][TB_DEPTH-2:0]
                                      : surv_q[P0][TB_DEPTH-2:0]), A};
    end

    // Strict '<' keeps the lowest index among equal minima, which is also
    // the lowest-index state whose normalised metric is zero.
    always_comb begin
        min_w = sum[0];
        best  = '0;
        for (int i = 1; i < N_STATES; i++) begin
            if (sum[i] < min_w) begin
                min_w = sum[i];
                best  = state_t'(i);
            end
        end
    end

    always_comb begin
        norm   = '0;
        pm_new = '0;
        for (int i = 0; i < N_STATES; i++) begin
            norm[i]   = sum[i] - min_w;
            pm_new[i] = norm[i][PM_W] ? {PM_W{1'b1}} : norm[i][PM_W-1:0];
        end
    end

    always_comb begin
        pm_d          = pm_q;
        surv_d        = surv_q;
        cnt_d         = cnt_q;
        out_valid_d   = 1'b0;
        out_bit_d     = out_bit_q;
        best_metric_d = best_metric_q;
        if (clear) begin
            pm_d          = PM_INIT;
            surv_d        = '0;
            cnt_d         = '0;
            out_bit_d     = 1'b0;
            best_metric_d = '0;
        end else if (bus.in_valid) begin
            pm_d   = pm_new;
            surv_d = surv_new;
            if (cnt_q != CNT_W'(TB_DEPTH))
                cnt_d = cnt_q + 1'b1;
            if (cnt_q >= CNT_W'(TB_DEPTH - 1)) begin
                out_valid_d   = 1'b1;
                out_bit_d     = surv_new[best][TB_DEPTH-1];
                best_metric_d = min_w[PM_W] ? {PM_W{1'b1}} : min_w[PM_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pm_q          <= PM_INIT;
            surv_q        <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_bit_q     <= 1'b0;
            best_metric_q <= '0;
        end else begin
            pm_q          <= pm_d;
            surv_q        <= surv_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_bit_q     <= out_bit_d;
            best_metric_q <= best_metric_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_bit     = out_bit_q;
    assign bus.best_metric = best_metric_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: directed frames through an encoder model; the expected
// decoded bit for accepted symbol j is simply the frame's d[j-TB_DEPTH+1].
module tb_viterbi_decoder;

    localparam int TB_DEPTH = 15;
    localparam int PM_W     = 6;
    localparam int FMAX     = 256;

    logic clk = 1'b0;
    logic reset;
    logic clear;

    always #5 clk = ~clk;

    viterbi_decoder_if #(.PM_W(PM_W)) bus ();

    viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: current frame's information bits and accepted-symbol count
    logic frame_d [FMAX];
    int   bm_mode  = 0;     // 0: best_metric must be 0, 1: must be <= 1
    int   m_cnt    = 0;
    int   pulses   = 0;
    int   first_j  = -1;
    logic exp_v, exp_zero, exp_bit;
    int   exp_j;
    logic dec_bits [$];
    logic ref_bits [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Compare process: predict at the active edge, check at the falling edge
    always begin
        @(posedge clk);
        exp_v    = 1'b0;
        exp_zero = 1'b0;
        exp_bit  = 1'b0;
        if (reset || clear) begin
            m_cnt    = 0;
            exp_zero = 1'b1;
        end else if (bus.in_valid) begin
            if (m_cnt >= TB_DEPTH - 1) begin
                exp_v   = 1'b1;
                exp_j   = m_cnt;
                exp_bit = (m_cnt - TB_DEPTH + 1 < FMAX) ? frame_d[m_cnt - TB_DEPTH + 1] : 1'b0;
            end
            m_cnt++;
        end
        @(negedge clk);
        if (reset) begin
            exp_zero = 1'b1;
            exp_v    = 1'b0;
            m_cnt    = 0;
        end
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_v});
        if (exp_zero) begin
            chk("out_bit_cleared", {31'b0, bus.out_bit}, 0);
            chk("best_metric_cleared", {26'b0, bus.best_metric}, 0);
        end
        if (exp_v && bus.out_valid) begin
            chk("out_bit", {31'b0, bus.out_bit}, {31'b0, exp_bit});
            if (bm_mode == 0)
                chk("best_metric_zero", {26'b0, bus.best_metric}, 0);
            else
                chk("best_metric_le1", {31'b0, (bus.best_metric > 1)}, 0);
            pulses++;
            if (first_j < 0) first_j = exp_j;
            dec_bits.push_back(bus.out_bit);
        end
    end

    task automatic cycle(input logic v, input logic a0, input logic a1, input logic clr);
        bus.in_valid = v;
        bus.c0       = a0;
        bus.c1       = a1;
        clear        = clr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clear        = 1'b0;
    endtask

    // Restart bookkeeping and, optionally, the DUT via clear
    task automatic new_frame(input logic do_clear);
        dec_bits.delete();
        pulses  = 0;
        first_j = -1;
        if (do_clear) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Encode frame_d[0..n-1] from the all-zero state and send it.
    // abort_kind 1: async reset before symbol abort_at; 2: clear with that symbol.
    task automatic run_frame(input int n, input bit flips, input bit gaps,
                             input int abort_at, input int abort_kind);
        logic d, d1, d2, p0, p1;
        d1 = 1'b0;
        d2 = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps)
                while ($urandom_range(0, 1) == 1) cycle(1'b0, 1'b0, 1'b0, 1'b0);
            d  = frame_d[i];
            p0 = d ^ d2;
            p1 = d ^ d1 ^ d2;
            if (flips && (i % 10 == 5)) begin
                if ((i / 10) % 2 == 0) p0 = ~p0;
                else                   p1 = ~p1;
            end
            if (i == abort_at && abort_kind == 1) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            if (i == abort_at && abort_kind == 2) begin
                cycle(1'b1, p0, p1, 1'b1);
                return;
            end
            cycle(1'b1, p0, p1, 1'b0);
            d2 = d1;
            d1 = d;
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < FMAX; i++)
            frame_d[i] = (i < n) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.c0       = 1'b0;
        bus.c1       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // All-zero frame
        for (int i = 0; i < FMAX; i++) frame_d[i] = 1'b0;
        new_frame(1'b1);
        run_frame(40, 1'b0, 1'b0, -1, 0);
        chk("zero_first_j", first_j, 14);
        chk("zero_pulses", pulses, 26);

        // Impulse: symbols 11,01,11 then zeros
        frame_d[0] = 1'b1;
        new_frame(1'b1);
        run_frame(40, 1'b0, 1'b0, -1, 0);
        chk("impulse_pulses", pulses, 26);
        chk("impulse_first_bit", {31'b0, dec_bits[0]}, 1);
        chk("impulse_second_bit", {31'b0, dec_bits[1]}, 0);

        // Random 200 bits + 2 zero tail, clean channel
        fill_random(200);
        new_frame(1'b1);
        run_frame(202, 1'b0, 1'b0, -1, 0);
        chk("random_pulses", pulses, 202 - (TB_DEPTH - 1));
        ref_bits = dec_bits;

        // Same stream, one flipped bit every 10 symbols
        bm_mode = 1;
        new_frame(1'b1);
        run_frame(202, 1'b1, 1'b0, -1, 0);
        chk("flip_pulses", pulses, 202 - (TB_DEPTH - 1));
        bm_mode = 0;

        // Same clean stream with random idle gaps
        new_frame(1'b1);
        run_frame(202, 1'b0, 1'b1, -1, 0);
        chk("gap_len", dec_bits.size(), ref_bits.size());
        for (int i = 0; i < ref_bits.size() && i < dec_bits.size(); i++)
            if (i % 20 == 0) chk("gap_vs_b2b", {31'b0, dec_bits[i]}, {31'b0, ref_bits[i]});

        // Reset mid-frame, then a fresh frame without clear
        fill_random(60);
        new_frame(1'b1);
        run_frame(60, 1'b0, 1'b0, 30, 1);
        fill_random(60);
        new_frame(1'b0);
        run_frame(60, 1'b0, 1'b0, -1, 0);
        chk("after_reset_first_j", first_j, 14);
        chk("after_reset_pulses", pulses, 46);

        // Clear together with in_valid drops that symbol
        fill_random(60);
        new_frame(1'b1);
        run_frame(60, 1'b0, 1'b0, 25, 2);
        fill_random(50);
        new_frame(1'b0);
        run_frame(50, 1'b0, 1'b0, -1, 0);
        chk("after_clear_first_j", first_j, 14);
        chk("after_clear_pulses", pulses, 36);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
